// File: rtl/dp_ctrl_if.sv
// dp_ctrl_if: host/datapath handshake and command bundle for dp_ctrl; DP_CTRL_ABORT_EN adds abort.
interface dp_ctrl_if;
  logic start;
  logic mode;
  logic in_valid;
  logic in_req;
  logic in_ack;
  logic out1;
  logic out2;
  logic out3;
  logic busy;
  logic done;
`ifdef DP_CTRL_ABORT_EN
  logic abort;
  modport master (output start, mode, in_valid, abort,
                  input in_req, in_ack, out1, out2, out3, busy, done);
  modport slave  (input start, mode, in_valid, abort,
                  output in_req, in_ack, out1, out2, out3, busy, done);
`else
  modport master (output start, mode, in_valid,
                  input in_req, in_ack, out1, out2, out3, busy, done);
  modport slave  (input start, mode, in_valid,
                  output in_req, in_ack, out1, out2, out3, busy, done);
`endif
endinterface

// File: rtl/dp_ctrl.sv
// dp_ctrl: cipher datapath sequencer (byte handshake, key expansion, run, capture).
// Optional DP_CTRL_ABORT_EN adds a synchronous abort back to IDLE.
module dp_ctrl #(
  parameter int RUN_CYCLES = 3,
  parameter int OUT_HOLD   = 2,
  parameter int CNT_W      = 3
) (
  input logic       clka,
  input logic       restart,
  dp_ctrl_if.slave  bus
);
  typedef enum logic [3:0] {
    IDLE, REQ_HI, LOAD_HI, REL_HI, REQ_LO, LOAD_LO, REL_LO, KEY1, KEY2, RUN, DONE
  } state_t;
  state_t state_q, state_d;
  logic mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] code_q, code_d;
  logic req_q, req_d, ack_q, ack_d, busy_q, busy_d, done_q, done_d;
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:    if (bus.start) begin
                 state_d = REQ_HI;
                 mode_d  = bus.mode;
               end
      REQ_HI:  state_d = bus.in_valid ? LOAD_HI : REQ_HI;
      LOAD_HI: state_d = REL_HI;
      REL_HI:  state_d = bus.in_valid ? REL_HI : REQ_LO;
      REQ_LO:  state_d = bus.in_valid ? LOAD_LO : REQ_LO;
      LOAD_LO: state_d = REL_LO;
      REL_LO:  state_d = bus.in_valid ? REL_LO : KEY1;
      KEY1:    state_d = KEY2;
      KEY2:    begin
                 state_d = RUN;
                 cnt_d   = '0;
               end
      RUN:     begin
                 state_d = (cnt_q == CNT_W'(RUN_CYCLES - 1)) ? DONE : RUN;
                 cnt_d   = (cnt_q == CNT_W'(RUN_CYCLES - 1)) ? '0 : cnt_q + 1'b1;
               end
      DONE:    begin
                 state_d = (cnt_q == CNT_W'(OUT_HOLD - 1)) ? IDLE : DONE;
                 cnt_d   = (cnt_q == CNT_W'(OUT_HOLD - 1)) ? '0 : cnt_q + 1'b1;
                 done_d  = (cnt_q == CNT_W'(OUT_HOLD - 1));
               end
      default: state_d = IDLE;
    endcase
`ifdef DP_CTRL_ABORT_EN
    if (bus.abort && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
`endif
    // Outputs are decoded from the next state so the registered codes line up with the state.
    req_d  = (state_d == REQ_HI) || (state_d == REQ_LO);
    ack_d  = (state_d == LOAD_HI) || (state_d == REL_HI) || (state_d == LOAD_LO) || (state_d == REL_LO);
    busy_d = (state_d != IDLE);
    code_d = (state_d == LOAD_HI) ? 3'b100 :
             (state_d == LOAD_LO) ? 3'b010 :
             (state_d == KEY1)    ? 3'b110 :
             (state_d == KEY2)    ? 3'b011 :
             (state_d == RUN || state_d == DONE) ? {mode_d, 2'b01} : 3'b000;
  end
  always_ff @(posedge clka or posedge restart)
    if (restart) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      code_q  <= 3'b000;
      req_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  assign {bus.out1, bus.out2, bus.out3} = code_q;
  assign bus.in_req = req_q;
  assign bus.in_ack = ack_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_dp_ctrl.sv
// tb_dp_ctrl: directed and randomized host traffic against a cycle-trace model of dp_ctrl.
module tb_dp_ctrl;
  localparam int RC = 3;
  localparam int OH = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dp_ctrl_if bus ();
  dp_ctrl #(.RUN_CYCLES(RC), .OUT_HOLD(OH), .CNT_W(3)) dut (.clka(clk), .restart(rst), .bus(bus));
  int tests = 0;
  int fails = 0;
  // Expected per-cycle outputs {code[2:0], in_req, in_ack, busy, done} and host in_valid for that cycle.
  logic [6:0] exp_q[$];
  logic       val_q[$];

  function automatic logic [6:0] obs();
    return {bus.out1, bus.out2, bus.out3, bus.in_req, bus.in_ack, bus.busy, bus.done};
  endfunction

  task automatic check(string tag, logic [6:0] e);
    tests++;
    assert (obs() === e) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs(), e);
    end
  endtask

  task automatic push(logic [2:0] c, logic r, logic a, logic b, logic d, logic v);
    exp_q.push_back({c, r, a, b, d});
    val_q.push_back(v);
  endtask

  // Host waits w REQ cycles before raising in_valid, then keeps it high for h ack cycles.
  task automatic build(logic m, int w1, int h1, int w2, int h2);
    exp_q.delete();
    val_q.delete();
    for (int p = 0; p < 2; p++) begin
      int w = p ? w2 : w1;
      int h = p ? h2 : h1;
      for (int j = 0; j <= w; j++) push(3'b000, 1'b1, 1'b0, 1'b1, 1'b0, j >= w);
      push(p ? 3'b010 : 3'b100, 1'b0, 1'b1, 1'b1, 1'b0, h > 0);
      for (int k = 1; k <= (h > 1 ? h : 1); k++) push(3'b000, 1'b0, 1'b1, 1'b1, 1'b0, k < h);
    end
    push(3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push(3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < RC + OH; k++) push({m, 2'b01}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run(string name, logic m, int w1, int h1, int w2, int h2, int rst_at, int abort_at);
    build(m, w1, h1, w2, h2);
    if (abort_at >= 0) begin
      while (exp_q.size() > abort_at + 1) begin
        void'(exp_q.pop_back());
        void'(val_q.pop_back());
      end
      push(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      push(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    check({name, "_idle"}, 7'b0);
    bus.start    = 1'b1;
    bus.mode     = m;
    bus.in_valid = 1'($urandom % 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      check($sformatf("%s[%0d]", name, i), exp_q[i]);
      if (i == rst_at) begin
        #2 rst = 1'b1;
        #1 check({name, "_rst_async"}, 7'b0);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check({name, "_rst_idle"}, 7'b0);
        return;
      end
      bus.in_valid = val_q[i];
      bus.start    = exp_q[i][1] ? 1'($urandom % 2) : 1'b0;
      bus.mode     = 1'($urandom % 2);
`ifdef DP_CTRL_ABORT_EN
      bus.abort    = (i == abort_at);
`endif
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.mode     = 1'b0;
    bus.in_valid = 1'b0;
`ifdef DP_CTRL_ABORT_EN
    bus.abort    = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset", 7'b0);
    rst = 1'b0;
    run("enc", 1'b0, 0, 0, 0, 0, -1, -1);
    run("dec", 1'b1, 0, 0, 0, 0, -1, -1);
    run("slow_hi", 1'b0, 0, 4, 0, 0, -1, -1);
    run("slow_req", 1'b1, 3, 0, 2, 2, -1, -1);
    run("rst_run", 1'b0, 0, 0, 0, 0, 9, -1);
    run("post_rst", 1'b1, 0, 0, 0, 0, -1, -1);
`ifdef DP_CTRL_ABORT_EN
    run("abort_req_lo", 1'b0, 0, 0, 0, 0, -1, 3);
    run("post_abort", 1'b0, 0, 0, 0, 0, -1, -1);
    run("abort_run", 1'b1, 1, 1, 0, 0, -1, 11);
`endif
    for (int n = 0; n < 8; n++)
      run($sformatf("rnd%0d", n), 1'($urandom % 2), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dp_ctrl.md
Name: dp_ctrl

Overview:
- Sequencer directly upstream of the 16-bit cipher datapath.
- Runs a 4-phase byte handshake with the host to collect the high and low data/key bytes.
- Drives the datapath's out1/out2/out3 command code through load, key expansion, encrypt/decrypt run and output capture.
- Reports busy/done to the host.

Parameters:
- RUN_CYCLES, 3, cycles the run code (001 enc / 101 dec) is held; must be >=3 to flush the three-stage cipher chain.
- OUT_HOLD, 2, cycles the run code stays asserted in DONE so the clkb-side output registers capture; must be >=1.
- CNT_W, 3, width of the shared cycle counter; must hold max(RUN_CYCLES, OUT_HOLD).

Ports:
- clka      input   1  single block clock; all state updates on posedge.
- restart   input   1  asynchronous, active-high reset.
- start     input   1  begin one operation; sampled only in IDLE.
- mode      input   1  0 = encrypt, 1 = decrypt; captured when start is accepted.
- in_valid  input   1  host has d_in/key_in bytes stable (4-phase request).
- in_req    output  1  controller wants a byte (REQ_HI/REQ_LO).
- in_ack    output  1  byte taken; held until host drops in_valid.
- out1      output  1  datapath command bit 1.
- out2      output  1  datapath command bit 2.
- out3      output  1  datapath command bit 3.
- busy      output  1  high in every state except IDLE.
- done      output  1  one-cycle pulse on the DONE->IDLE transition.

Behaviour:
- Clocking and reset:
  - One clock, clka; reset is restart, asynchronous and active-high.
  - All outputs are registered (Moore, decoded from state) so the datapath, which samples on negedge clka, sees glitch-free codes.
  - Reset values: state IDLE, code 000, in_req=0, in_ack=0, busy=0, done=0, mode_r=0, counter=0.
  - restart asserted mid-operation aborts immediately to these values; the datapath is cleared by the same restart.
- States and codes (out1 out2 out3):
  - IDLE 000: start=1 -> latch mode_r, go to REQ_HI. A start seen in any other state is ignored.
  - REQ_HI 000, in_req=1: in_valid=1 -> LOAD_HI.
  - LOAD_HI 100, in_ack=1: one cycle -> REL_HI.
  - REL_HI 000, in_ack=1: stay until in_valid=0 -> REQ_LO.
  - REQ_LO 000, in_req=1: in_valid=1 -> LOAD_LO.
  - LOAD_LO 010, in_ack=1: one cycle -> REL_LO.
  - REL_LO 000, in_ack=1: in_valid=0 -> KEY1.
  - KEY1 110: one cycle -> KEY2.
  - KEY2 011: one cycle -> RUN, counter=0.
  - RUN {mode_r,0,1}: RUN_CYCLES cycles, counter increments each cycle; on counter==RUN_CYCLES-1 go to DONE with counter=0.
  - DONE {mode_r,0,1}: OUT_HOLD cycles; on the last cycle go to IDLE and pulse done.
- Handshake rules:
  - The host must hold d_in/key_in stable from raising in_valid until it sees in_ack; the datapath samples in LOAD_x.
  - in_valid already high on entry to REQ_x advances in the next cycle.
  - in_valid dropping during REQ_x returns nothing; the block keeps waiting.
- Codes 000 and 111 are never produced outside the listed states; 111 is never driven.
- Minimum latency from start accepted to done, with in_valid pre-asserted and dropped the cycle ack is seen: 1+1+1+1+1+1+1+1 + RUN_CYCLES + OUT_HOLD = 13 cycles at defaults.

Optional Feature:
- Macro: DP_CTRL_ABORT_EN.
- Defined:
  - Adds input abort (1 bit).
  - abort=1 in any non-IDLE state forces IDLE with code 000 on the next posedge.
  - in_req, in_ack and busy are cleared; done is not pulsed.
  - abort has priority over all other transitions but not over restart.
- Undefined: no abort port; only restart can cancel an operation.

Test Plan:
- Reset: assert restart mid-RUN -> out1..3=000, busy=0, in_req=0, in_ack=0 asynchronously; after release, state IDLE.
- Encrypt sequence: mode=0, start=1, host bytes d=0xA5/0x3C, key=0x12/0x34 with in_valid dropped one cycle after ack. Required:
  - code order 000,100,000,000,010,000,110,011,001x3,001x2,000.
  - done pulses exactly once; total 13 cycles.
- Decrypt: mode=1 latched, mode toggled to 0 after start -> RUN/DONE codes remain 101 for 5 cycles.
- Slow host: hold in_valid high 4 cycles after ack in REL_HI -> code stays 000, in_ack=1 for 4 cycles, no second LOAD_HI.
- start pulsed while busy (in RUN) -> ignored; exactly one done, no restart of sequence.
- DP_CTRL_ABORT_EN defined: abort=1 in REQ_LO -> next cycle IDLE, code 000, busy=0, done stays 0; a new start then completes normally.
